lif_array: RTL and testbench
============================

LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of neuron channels (range 2..16).
REQ-002 Parameter W, default 8, SHALL set the membrane-state and stimulus width in bits.
REQ-003 Parameter LEAK_SHIFT, default 1, SHALL set the leak as state >> LEAK_SHIFT per update.
REQ-004 Parameter THRESHOLD, default 200, SHALL set the firing threshold (range 1..2^W-1).
REQ-005 Parameter REFRAC, default 2, SHALL set the refractory length in channel updates (range 0..15).
REQ-006 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-008 ena  input  1  SHALL allow updates when high.
REQ-009 stim_in  input  NUM_CH*W  SHALL carry the stimulus current for channel c in bits [c*W +: W].
REQ-010 sel_in  input  $clog2(NUM_CH)  SHALL select the channel shown on state_out.
REQ-011 state_out  output  W  SHALL carry the registered membrane state of the selected channel.
REQ-012 spike_out  output  NUM_CH  SHALL carry one spike flag per channel.
REQ-013 frame_done  output  1  SHALL pulse when all channels have been updated once.
REQ-014 spike_cnt  output  16  SHALL carry the total spike count (see Configuration).

Function
REQ-015 A channel pointer SHALL advance 0,1..NUM_CH-1,0 once per cycle while ena=1; exactly one channel SHALL be updated per cycle, namely the channel at the pointer.
REQ-016 When ena=0, the pointer, states, refractory counters, spike_out, frame_done and spike_cnt SHALL hold their values.
REQ-017 Refractory update (refrac[c]!=0): state[c] SHALL be set to 0, refrac[c] SHALL decrement and spike_out[c] SHALL be set to 0.
REQ-018 Integrating update (refrac[c]==0): next = state - (state >> LEAK_SHIFT) + stim, computed in W+1 bits and saturated to 2^W-1.
REQ-019 If next >= THRESHOLD: state[c] SHALL be set to 0, spike_out[c] SHALL be set to 1 and refrac[c] SHALL be set to REFRAC. Otherwise state[c] SHALL be set to next and spike_out[c] SHALL be set to 0.
REQ-020 spike_out[c] SHALL change only on updates of channel c, so a spike holds for NUM_CH cycles.
REQ-021 state_out SHALL be registered from state[sel_in] with 1-cycle latency; a sel_in value >= NUM_CH SHALL yield 0.
REQ-022 frame_done SHALL be 1 for exactly the one cycle following the update of channel NUM_CH-1.
REQ-023 With REFRAC=0, a fired channel SHALL integrate again on its next update.

Reset
REQ-024 rst_n low SHALL immediately set all of the following to 0: pointer, all states, all refractory counters, spike_out, state_out, frame_done and spike_cnt. A reset in mid-frame SHALL restart at channel 0.

Configuration
REQ-025 With macro LIF_ARRAY_SPIKE_CNT_EN defined, spike_cnt SHALL increment by 1 per firing update and saturate at 16'hFFFF.
REQ-026 Without LIF_ARRAY_SPIKE_CNT_EN, spike_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-027 Package lif_pkg SHALL hold the default parameter constants and the saturating-add width rule.
REQ-028 A single combinational sub-module lif_update SHALL compute the next state, spike and refrac values for one channel. It SHALL be instantiated once and shared across channels through the pointer mux.

Verification (NUM_CH=4, W=8, LEAK_SHIFT=1, THRESHOLD=200, REFRAC=2 unless stated)
REQ-029 Reset: assert rst_n=0 mid-frame. Required response: all outputs 0 at once; after release, ch0 is updated first.
REQ-030 Integration: stim ch0=100, ena=1, sel_in=0. Required response: state_out sequence 100,150,175,188,194,197,199; spike_out[0]=1 on the 8th update with state 0; the next 2 updates hold state 0; the 11th update gives 100.
REQ-031 Saturation and instant fire: stim ch1=255. Required response: spike_out[1]=1 on the first update; with LIF_ARRAY_SPIKE_CNT_EN defined, spike_cnt=1.
REQ-032 Freeze: drive ena=0 for 10 cycles mid-frame. Required response: all outputs unchanged; updates resume at the same channel.
REQ-033 Frame: run with ena=1 continuously. Required response: frame_done high every 4th cycle; with NUM_CH=3 and sel_in=3, state_out=0.
REQ-034 Macro off: repeat REQ-031 without LIF_ARRAY_SPIKE_CNT_EN. Required response: spike_cnt stays 0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants for the leaky integrate-and-fire neuron array:
// default parameter values, refractory counter width and the width rule
// for the unsaturated integration sum.
package lif_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_W          = 8;
  localparam int DEF_LEAK_SHIFT = 1;
  localparam int DEF_THRESHOLD  = 200;
  localparam int DEF_REFRAC     = 2;

  // Refractory lengths go up to 15 updates.
  localparam int REFRAC_W = 4;

  // state - leak + stim never exceeds 2*(2^w-1), so one extra bit is enough
  // to see the overflow before saturating back to w bits.
  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational update of one LIF channel: leak, integrate, saturate,
// threshold test and refractory countdown. A single instance is shared by
// all channels through the channel pointer in lif_array.
module lif_update
  import lif_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int REFRAC     = DEF_REFRAC
) (
  input  logic [W-1:0]        state,
  input  logic [REFRAC_W-1:0] refrac,
  input  logic [W-1:0]        stim,
  output logic [W-1:0]        next_state,
  output logic [REFRAC_W-1:0] next_refrac,
  output logic                spike
);

  localparam int SW = sum_width(W);
  localparam logic [SW-1:0]       SAT_LIMIT = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0]        THR       = W'(THRESHOLD);
  localparam logic [REFRAC_W-1:0] REF_LOAD  = REFRAC_W'(REFRAC);
  localparam logic [REFRAC_W-1:0] REF_ONE   = REFRAC_W'(1);

  logic [SW-1:0] sum;
  logic [W-1:0]  sat;

  // Integrate in W+1 bits, clamp to full scale, then decide fire/refractory.
  always_comb begin
    sum         = {1'b0, state} - {1'b0, (state >> LEAK_SHIFT)} + {1'b0, stim};
    sat         = (sum > SAT_LIMIT) ? {W{1'b1}} : sum[W-1:0];
    next_state  = '0;
    next_refrac = '0;
    spike       = 1'b0;
    if (refrac != '0) begin
      next_refrac = refrac - REF_ONE;
    end else if (sat >= THR) begin
      spike       = 1'b1;
      next_refrac = REF_LOAD;
    end else begin
      next_state  = sat;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed array of NUM_CH leaky integrate-and-fire neurons.
// One channel is updated per enabled cycle in round-robin order; a frame
// ends after channel NUM_CH-1 and is flagged by a one-cycle frame_done.
// Optional total spike counter: define LIF_ARRAY_SPIKE_CNT_EN.
//
// Flow control: ena is a plain enable with no back-pressure. A cycle with
// ena=1 performs exactly one channel update; a cycle with ena=0 freezes
// pointer, states, refractory counters, spike_out, frame_done and spike_cnt.
module lif_array
  import lif_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int W          = DEF_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int REFRAC     = DEF_REFRAC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [NUM_CH*W-1:0]        stim_in,
  input  logic [$clog2(NUM_CH)-1:0]  sel_in,
  output logic [W-1:0]               state_out,
  output logic [NUM_CH-1:0]          spike_out,
  output logic                       frame_done,
  output logic [15:0]                spike_cnt
);

  localparam int PW = $clog2(NUM_CH);
  localparam logic [PW-1:0] LAST    = PW'(NUM_CH - 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]       ptr;
  logic [W-1:0]        state  [NUM_CH];
  logic [REFRAC_W-1:0] refrac [NUM_CH];

  logic [W-1:0]        cur_state;
  logic [REFRAC_W-1:0] cur_refrac;
  logic [W-1:0]        cur_stim;
  logic [W-1:0]        sel_state;
  logic [W-1:0]        upd_state;
  logic [REFRAC_W-1:0] upd_refrac;
  logic                upd_spike;

  // Pointer mux into the shared update unit, plus the observation mux
  // (out-of-range selects read as 0).
  always_comb begin
    cur_state  = '0;
    cur_refrac = '0;
    cur_stim   = '0;
    sel_state  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ptr == PW'(c)) begin
        cur_state  = state[c];
        cur_refrac = refrac[c];
        cur_stim   = stim_in[c*W +: W];
      end
      if (sel_in == PW'(c)) begin
        sel_state = state[c];
      end
    end
  end

  lif_update #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .THRESHOLD  (THRESHOLD),
    .REFRAC     (REFRAC)
  ) u_update (
    .state       (cur_state),
    .refrac      (cur_refrac),
    .stim        (cur_stim),
    .next_state  (upd_state),
    .next_refrac (upd_refrac),
    .spike       (upd_spike)
  );

  // Write back the pointed channel, advance the pointer, flag frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      spike_out  <= '0;
      frame_done <= 1'b0;
      state_out  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]  <= '0;
        refrac[c] <= '0;
      end
    end else begin
      state_out <= sel_state;
      if (ena) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ptr == PW'(c)) begin
            state[c]     <= upd_state;
            refrac[c]    <= upd_refrac;
            spike_out[c] <= upd_spike;
          end
        end
        ptr        <= (ptr == LAST) ? '0 : ptr + PTR_ONE;
        frame_done <= (ptr == LAST);
      end
    end
  end

`ifdef LIF_ARRAY_SPIKE_CNT_EN
  logic [15:0] cnt;

  // Count firing updates, sticking at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena && upd_spike && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign spike_cnt = cnt;
`else
  assign spike_cnt = '0;
`endif

endmodule

// File: tb/tb_lif_array.sv
// Scoreboard bench for lif_array. The driver applies one stimulus per cycle
// on the falling edge, advances an arithmetic reference model and queues the
// expected outputs; the monitor pops and compares after each rising edge.
// A second instance with NUM_CH=3 checks 3-cycle frames and sel_in=3 -> 0.
module tb_lif_array;

  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int THR    = 200;
  localparam int REF    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  ena;
  logic [NUM_CH*W-1:0]   stim;
  logic [1:0]            sel;
  logic [W-1:0]          state_out;
  logic [NUM_CH-1:0]     spike_out;
  logic                  frame_done;
  logic [15:0]           spike_cnt;

  logic [3*W-1:0]        stim3;
  logic [1:0]            sel3;
  logic [W-1:0]          state_out3;
  logic [2:0]            spike_out3;
  logic                  frame_done3;
  logic [15:0]           spike_cnt3;

  lif_array #(.NUM_CH(NUM_CH), .W(W), .LEAK_SHIFT(1), .THRESHOLD(THR), .REFRAC(REF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .stim_in    (stim),
    .sel_in     (sel),
    .state_out  (state_out),
    .spike_out  (spike_out),
    .frame_done (frame_done),
    .spike_cnt  (spike_cnt)
  );

  lif_array #(.NUM_CH(3), .W(W), .LEAK_SHIFT(1), .THRESHOLD(THR), .REFRAC(REF)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .stim_in    (stim3),
    .sel_in     (sel3),
    .state_out  (state_out3),
    .spike_out  (spike_out3),
    .frame_done (frame_done3),
    .spike_cnt  (spike_cnt3)
  );

  // ---------------- reference model ----------------
  int m_state [NUM_CH];
  int m_ref   [NUM_CH];
  int m_spk   [NUM_CH];
  int m_ptr, m_fd, m_cnt;
  int m3_ptr, m3_fd;

  typedef struct packed {
    logic [W-1:0]      so;
    logic [NUM_CH-1:0] spk;
    logic              fd;
    logic [15:0]       cnt;
    logic              fd3;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_state[c] = 0;
      m_ref[c]   = 0;
      m_spk[c]   = 0;
    end
    m_ptr  = 0;
    m_fd   = 0;
    m_cnt  = 0;
    m3_ptr = 0;
    m3_fd  = 0;
  endtask

  // Neuron behaviour straight from the rules: leak by halving, add the
  // stimulus, clamp to 255, fire at >= THR, then sit out REF updates at 0.
  task automatic model_step(input bit e, input logic [NUM_CH*W-1:0] s, input int sl);
    exp_t x;
    int c, v;
    x.so = W'(m_state[sl]);
    if (e) begin
      c = m_ptr;
      if (m_ref[c] > 0) begin
        m_state[c] = 0;
        m_ref[c]   = m_ref[c] - 1;
        m_spk[c]   = 0;
      end else begin
        v = m_state[c] - (m_state[c] / 2) + int'(s[c*W +: W]);
        if (v > 255) v = 255;
        if (v >= THR) begin
          m_state[c] = 0;
          m_ref[c]   = REF;
          m_spk[c]   = 1;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
          m_state[c] = v;
          m_spk[c]   = 0;
        end
      end
      m_fd   = (c == NUM_CH - 1) ? 1 : 0;
      m_ptr  = (c + 1) % NUM_CH;
      m3_fd  = (m3_ptr == 2) ? 1 : 0;
      m3_ptr = (m3_ptr + 1) % 3;
    end
    for (int k = 0; k < NUM_CH; k++) x.spk[k] = m_spk[k][0];
    x.fd  = m_fd[0];
`ifdef LIF_ARRAY_SPIKE_CNT_EN
    x.cnt = 16'(m_cnt);
`else
    x.cnt = 16'h0;
`endif
    x.fd3 = m3_fd[0];
    exp_q.push_back(x);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_zero();
    check("rst_state_out",  32'(state_out),   0);
    check("rst_spike_out",  32'(spike_out),   0);
    check("rst_frame_done", 32'(frame_done),  0);
    check("rst_spike_cnt",  32'(spike_cnt),   0);
    check("rst_state_out3", 32'(state_out3),  0);
    check("rst_spike_out3", 32'(spike_out3),  0);
    check("rst_frame_done3",32'(frame_done3), 0);
  endtask

  // Monitor: every enabled-run cycle presents one output set.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state_out",   32'(state_out),   32'(e.so));
      check("spike_out",   32'(spike_out),   32'(e.spk));
      check("frame_done",  32'(frame_done),  32'(e.fd));
      check("spike_cnt",   32'(spike_cnt),   32'(e.cnt));
      check("frame_done3", 32'(frame_done3), 32'(e.fd3));
      check("state_out3",  32'(state_out3),  0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit e, input logic [NUM_CH*W-1:0] s, input int sl);
    @(negedge clk);
    ena   = e;
    stim  = s;
    sel   = 2'(sl);
    stim3 = 24'($urandom);
    model_step(e, s, sl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ena   = 1'b0;
    rst_n = 1'b0;
    #2;
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [NUM_CH*W-1:0] rand_stim();
    logic [NUM_CH*W-1:0] s;
    for (int c = 0; c < NUM_CH; c++) begin
      s[c*W +: W] = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 130));
    end
    return s;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    stim  = '0;
    sel   = 2'd0;
    stim3 = '0;
    sel3  = 2'd3;
    model_reset();
    #1;
    check_zero();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Steady stimulus on channel 0: integrate, fire, refractory, restart.
    repeat (48) drive(1'b1, 32'h0000_0064, 0);

    // Reset in mid-frame, then channel 1 at full scale fires at once.
    repeat (2) drive(1'b1, rand_stim(), 1);
    do_reset();
    repeat (12) drive(1'b1, 32'h0000_FF00, 1);

    // Freeze for 10 cycles mid-frame, then resume.
    repeat (6) drive(1'b1, rand_stim(), $urandom_range(0, 3));
    repeat (10) drive(1'b0, rand_stim(), $urandom_range(0, 3));
    repeat (6) drive(1'b1, rand_stim(), $urandom_range(0, 3));

    // Randomized run with occasional stalls and one more reset.
    repeat (200) drive($urandom_range(0, 7) != 0, rand_stim(), $urandom_range(0, 3));
    do_reset();
    repeat (200) drive($urandom_range(0, 7) != 0, rand_stim(), $urandom_range(0, 3));

    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
